// File: rtl/mem_load_stage.sv
// rtl/mem_load_stage.sv - MEM pipeline stage: waits for data-SRAM responses, aligns loads, forwards results.
module mem_load_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int PC_W   = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         es_to_ms_valid,
    output logic                         ms_allowin,
    input  logic [PC_W+XLEN+REG_AW+5:0]  es_to_ms_bus,
    input  logic                         ws_allowin,
    output logic                         ms_to_ws_valid,
    output logic [REG_AW+XLEN+PC_W:0]    ms_to_ws_bus,
    input  logic                         data_sram_data_ok,
    input  logic [XLEN-1:0]              data_sram_rdata,
    input  logic                         flush,
    output logic                         ms_fwd_valid,
    output logic [REG_AW-1:0]            ms_fwd_dest,
    output logic [XLEN-1:0]              ms_fwd_data,
    output logic                         ms_fwd_stall
);

    localparam int BUS_W = PC_W + XLEN + REG_AW + 6;
    localparam int OFF_W = $clog2(XLEN / 8);

    logic              ms_valid;
    logic [BUS_W-1:0]  ms_bus;
    logic              data_buf_valid;
    logic [XLEN-1:0]   data_buf;
    logic [1:0]        cancel_cnt;

    logic              ms_mem_req;
    logic [2:0]        ms_ld_op;
    logic              ms_res_from_mem;
    logic              ms_gr_we;
    logic [REG_AW-1:0] ms_dest;
    logic [XLEN-1:0]   ms_alu_result;
    logic [PC_W-1:0]   ms_pc;

    assign ms_mem_req      = ms_bus[BUS_W-1];
    assign ms_ld_op        = ms_bus[BUS_W-2 -: 3];
    assign ms_res_from_mem = ms_bus[BUS_W-5];
    assign ms_gr_we        = ms_bus[BUS_W-6];
    assign ms_dest         = ms_bus[PC_W+XLEN +: REG_AW];
    assign ms_alu_result   = ms_bus[PC_W +: XLEN];
    assign ms_pc           = ms_bus[PC_W-1:0];

    logic es_mem_req;
    logic resp_ok;
    logic resp_take;
    logic ms_ready_go;
    logic ms_leave;

    assign es_mem_req = es_to_ms_bus[BUS_W-1];
    // A response only belongs to the current instruction once all cancelled ones have drained.
    assign resp_ok     = data_sram_data_ok && (cancel_cnt == 2'd0);
    assign resp_take   = ms_valid && ms_mem_req && !data_buf_valid && resp_ok;
    assign ms_ready_go = !ms_mem_req || data_buf_valid || resp_ok;
    assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
    assign ms_leave    = ms_valid && ms_ready_go && ws_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (flush) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
        if (!reset && !flush && es_to_ms_valid && ms_allowin) begin
            ms_bus <= es_to_ms_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush || ms_leave) begin
            data_buf_valid <= 1'b0;
        end else if (resp_take) begin
            data_buf_valid <= 1'b1;
            data_buf       <= data_sram_rdata;
        end
    end

    logic       inc_cur;
    logic       inc_es;
    logic       dec;
    logic [2:0] cnt_sum;

    assign inc_cur = flush && ms_valid && ms_mem_req && !data_buf_valid && !resp_ok;
    assign inc_es  = flush && es_to_ms_valid && es_mem_req;
    assign dec     = data_sram_data_ok && (cancel_cnt != 2'd0);
    assign cnt_sum = {1'b0, cancel_cnt} + {2'b00, inc_cur} + {2'b00, inc_es} - {2'b00, dec};

    always_ff @(posedge clk) begin
        if (reset) begin
            cancel_cnt <= 2'd0;
        end else if (cnt_sum > 3'd2) begin
            cancel_cnt <= 2'd2;
        end else begin
            cancel_cnt <= cnt_sum[1:0];
        end
    end

    logic [XLEN-1:0]  mem_rdata;
    logic [OFF_W+2:0] shamt;
    logic [XLEN-1:0]  raw;
    logic [XLEN-1:0]  load_val;
    logic [XLEN-1:0]  final_result;

    assign mem_rdata = data_buf_valid ? data_buf : data_sram_rdata;
    assign shamt     = {ms_alu_result[OFF_W-1:0], 3'b000};
    assign raw       = mem_rdata >> shamt;

    always_comb begin
        load_val = raw;
        case (ms_ld_op)
            3'b000:  load_val = XLEN'($signed(raw[31:0]));
            3'b001:  load_val = XLEN'($signed(raw[7:0]));
            3'b010:  load_val = XLEN'(raw[7:0]);
            3'b011:  load_val = XLEN'($signed(raw[15:0]));
            3'b100:  load_val = XLEN'(raw[15:0]);
            3'b101:  load_val = XLEN'(raw[31:0]);
            default: load_val = raw;
        endcase
    end

    assign final_result = ms_res_from_mem ? load_val : ms_alu_result;
    assign ms_to_ws_bus = {ms_gr_we, ms_dest, final_result, ms_pc};

    assign ms_fwd_valid = ms_valid && ms_gr_we && (ms_dest != '0);
    assign ms_fwd_dest  = ms_dest;
    assign ms_fwd_data  = final_result;
    assign ms_fwd_stall = ms_fwd_valid && ms_res_from_mem && !ms_ready_go;

endmodule

// File: tb/tb_mem_load_stage.sv
// tb/tb_mem_load_stage.sv - scoreboard bench for mem_load_stage at XLEN=32 and XLEN=64.
module tb_mem_load_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         es_to_ms_valid, ms_allowin, ws_allowin, ms_to_ws_valid;
    logic [74:0]  es_to_ms_bus;
    logic [69:0]  ms_to_ws_bus;
    logic         data_ok, flush, fwd_valid, fwd_stall;
    logic [31:0]  rdata, fwd_data;
    logic [4:0]   fwd_dest;

    logic         es_valid64, allowin64, ws_allowin64, ws_valid64;
    logic [106:0] es_bus64;
    logic [101:0] ws_bus64;
    logic         data_ok64, flush64, fwd_valid64, fwd_stall64;
    logic [63:0]  rdata64, fwd_data64;
    logic [4:0]   fwd_dest64;

    always #5 clk = ~clk;

    mem_load_stage u_dut (
        .clk(clk), .reset(reset),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin), .es_to_ms_bus(es_to_ms_bus),
        .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .data_sram_data_ok(data_ok), .data_sram_rdata(rdata), .flush(flush),
        .ms_fwd_valid(fwd_valid), .ms_fwd_dest(fwd_dest), .ms_fwd_data(fwd_data),
        .ms_fwd_stall(fwd_stall)
    );

    mem_load_stage #(.XLEN(64)) u_dut64 (
        .clk(clk), .reset(reset),
        .es_to_ms_valid(es_valid64), .ms_allowin(allowin64), .es_to_ms_bus(es_bus64),
        .ws_allowin(ws_allowin64), .ms_to_ws_valid(ws_valid64), .ms_to_ws_bus(ws_bus64),
        .data_sram_data_ok(data_ok64), .data_sram_rdata(rdata64), .flush(flush64),
        .ms_fwd_valid(fwd_valid64), .ms_fwd_dest(fwd_dest64), .ms_fwd_data(fwd_data64),
        .ms_fwd_stall(fwd_stall64)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [69:0]  exp_q[$];
    logic [69:0]  exp_v;
    logic [101:0] exp64_q[$];
    logic [101:0] exp64_v;

    function automatic logic [74:0] mk32(input logic mr, input logic [2:0] op, input logic rfm,
                                         input logic we, input logic [4:0] d,
                                         input logic [31:0] alu, input logic [31:0] pc);
        return {mr, op, rfm, we, d, alu, pc};
    endfunction

    function automatic logic [106:0] mk64(input logic mr, input logic [2:0] op, input logic rfm,
                                          input logic we, input logic [4:0] d,
                                          input logic [63:0] alu, input logic [31:0] pc);
        return {mr, op, rfm, we, d, alu, pc};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; es_to_ms_valid = 1'b1; flush = 1'b1; data_ok = 1'b1;
        es_to_ms_bus = mk32(1'b1, 3'b000, 1'b1, 1'b1, 5'd1, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0; es_to_ms_valid = 1'b0; flush = 1'b0; data_ok = 1'b0;
        #1;
        n_checks++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin: got %b expected 1", ms_allowin); end
        n_checks++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ws_valid: got %b expected 0", ms_to_ws_valid); end
        n_checks++; if (fwd_valid !== 1'b0 || fwd_stall !== 1'b0) begin n_fail++; $display("FAIL reset_fwd: got %b%b expected 00", fwd_valid, fwd_stall); end
        n_checks++; if (allowin64 !== 1'b1 || ws_valid64 !== 1'b0) begin n_fail++; $display("FAIL reset_x64: got %b%b expected 10", allowin64, ws_valid64); end
    endtask

    task automatic test_alu();
        @(negedge clk);
        es_to_ms_valid = 1'b1; ws_allowin = 1'b1;
        es_to_ms_bus = mk32(1'b0, 3'b000, 1'b0, 1'b1, 5'd3, 32'h1234, 32'h100);
        exp_q.push_back({1'b1, 5'd3, 32'h1234, 32'h100});
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
        n_checks++; if (ms_to_ws_valid !== 1'b1) begin n_fail++; $display("FAIL alu_valid: got %b expected 1", ms_to_ws_valid); end
        exp_v = exp_q.pop_front();
        n_checks++; if (ms_to_ws_bus !== exp_v) begin n_fail++; $display("FAIL alu_bus: got %h expected %h", ms_to_ws_bus, exp_v); end
        n_checks++; if (fwd_valid !== 1'b1 || fwd_stall !== 1'b0 || fwd_data !== 32'h1234 || fwd_dest !== 5'd3)
            begin n_fail++; $display("FAIL alu_fwd: got v%b s%b d%h r%0d expected v1 s0 d1234 r3", fwd_valid, fwd_stall, fwd_data, fwd_dest); end
    endtask

    task automatic test_lb_stall();
        @(negedge clk);
        es_to_ms_valid = 1'b1; ws_allowin = 1'b1; data_ok = 1'b0;
        es_to_ms_bus = mk32(1'b1, 3'b001, 1'b1, 1'b1, 5'd5, 32'h1002, 32'h200);
        exp_q.push_back({1'b1, 5'd5, 32'hFFFF_FF80, 32'h200});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            es_to_ms_valid = 1'b0;
            #1;
            n_checks++; if (fwd_stall !== 1'b1 || ms_to_ws_valid !== 1'b0)
                begin n_fail++; $display("FAIL lb_stall%0d: got stall %b valid %b expected 1 0", i, fwd_stall, ms_to_ws_valid); end
        end
        @(negedge clk);
        data_ok = 1'b1; rdata = 32'h0080_0000;
        #1;
        exp_v = exp_q.pop_front();
        n_checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp_v || fwd_stall !== 1'b0)
            begin n_fail++; $display("FAIL lb_result: got v%b %h s%b expected v1 %h s0", ms_to_ws_valid, ms_to_ws_bus, fwd_stall, exp_v); end
        @(negedge clk);
        data_ok = 1'b0;
    endtask

    task automatic test_lhu_buffered();
        @(negedge clk);
        es_to_ms_valid = 1'b1; ws_allowin = 1'b1;
        es_to_ms_bus = mk32(1'b1, 3'b100, 1'b1, 1'b1, 5'd6, 32'h2002, 32'h300);
        exp_q.push_back({1'b1, 5'd6, 32'h0000_8001, 32'h300});
        @(negedge clk);
        es_to_ms_valid = 1'b0; ws_allowin = 1'b0; data_ok = 1'b1; rdata = 32'h8001_0000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            data_ok = 1'b0; rdata = 32'h5555_5555;
            #1;
            n_checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h0000_8001)
                begin n_fail++; $display("FAIL lhu_hold%0d: got v%b %h expected v1 00008001", i, ms_to_ws_valid, ms_to_ws_bus[63:32]); end
        end
        @(negedge clk);
        ws_allowin = 1'b1;
        #1;
        exp_v = exp_q.pop_front();
        n_checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp_v)
            begin n_fail++; $display("FAIL lhu_result: got v%b %h expected v1 %h", ms_to_ws_valid, ms_to_ws_bus, exp_v); end
        @(negedge clk);
        #1;
        n_checks++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL lhu_leave: got %b expected 0", ms_to_ws_valid); end
    endtask

    task automatic test_store();
        @(negedge clk);
        es_to_ms_valid = 1'b1; ws_allowin = 1'b1;
        es_to_ms_bus = mk32(1'b1, 3'b000, 1'b0, 1'b0, 5'd0, 32'h7000, 32'h700);
        exp_q.push_back({1'b0, 5'd0, 32'h7000, 32'h700});
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
        n_checks++; if (ms_to_ws_valid !== 1'b0 || fwd_valid !== 1'b0)
            begin n_fail++; $display("FAIL store_wait: got v%b f%b expected 0 0", ms_to_ws_valid, fwd_valid); end
        @(negedge clk);
        data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
        #1;
        exp_v = exp_q.pop_front();
        n_checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp_v)
            begin n_fail++; $display("FAIL store_result: got v%b %h expected v1 %h", ms_to_ws_valid, ms_to_ws_bus, exp_v); end
        @(negedge clk);
        data_ok = 1'b0;
    endtask

    task automatic test_flush_cancel();
        @(negedge clk);
        es_to_ms_valid = 1'b1; ws_allowin = 1'b1;
        es_to_ms_bus = mk32(1'b1, 3'b000, 1'b1, 1'b1, 5'd6, 32'h3000, 32'h500);
        @(negedge clk);
        es_to_ms_bus = mk32(1'b1, 3'b000, 1'b1, 1'b1, 5'd8, 32'h3008, 32'h504);
        flush = 1'b1;
        #1;
        n_checks++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", ms_to_ws_valid); end
        @(negedge clk);
        flush = 1'b0;
        es_to_ms_bus = mk32(1'b1, 3'b000, 1'b1, 1'b1, 5'd7, 32'h3004, 32'h508);
        exp_q.push_back({1'b1, 5'd7, 32'hCAFE_F00D, 32'h508});
        #1;
        n_checks++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL flush_allowin: got %b expected 1", ms_allowin); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            es_to_ms_valid = 1'b0; data_ok = 1'b1; rdata = 32'h1111_1111 * (i + 1);
            #1;
            n_checks++; if (ms_to_ws_valid !== 1'b0 || fwd_stall !== 1'b1)
                begin n_fail++; $display("FAIL cancel_drop%0d: got v%b s%b expected 0 1", i, ms_to_ws_valid, fwd_stall); end
        end
        @(negedge clk);
        rdata = 32'hCAFE_F00D;
        #1;
        exp_v = exp_q.pop_front();
        n_checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp_v)
            begin n_fail++; $display("FAIL cancel_result: got v%b %h expected v1 %h", ms_to_ws_valid, ms_to_ws_bus, exp_v); end
        @(negedge clk);
        data_ok = 1'b0;
        #1;
        n_checks++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL cancel_leave: got %b expected 0", ms_to_ws_valid); end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got  = 0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            @(negedge clk);
            es_to_ms_valid = (sent < 8);
            es_to_ms_bus = mk32(1'b0, 3'b000, 1'b0, 1'b1, 5'(sent + 1), 32'(32'hA000 + sent), 32'(32'h400 + 4 * sent));
            ws_allowin = 1'($urandom_range(0, 1));
            #1;
            if (ms_to_ws_valid && ws_allowin) begin
                exp_v = exp_q.pop_front();
                n_checks++; if (ms_to_ws_bus !== exp_v)
                    begin n_fail++; $display("FAIL b2b_item%0d: got %h expected %h", got, ms_to_ws_bus, exp_v); end
                got++;
            end
            if (es_to_ms_valid && ms_allowin) begin
                exp_q.push_back({1'b1, 5'(sent + 1), 32'(32'hA000 + sent), 32'(32'h400 + 4 * sent)});
                sent++;
            end
        end
        n_checks++; if (got != 8) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", got); end
        @(negedge clk);
        es_to_ms_valid = 1'b0; ws_allowin = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        es_to_ms_valid = 1'b1; ws_allowin = 1'b1;
        es_to_ms_bus = mk32(1'b1, 3'b000, 1'b1, 1'b1, 5'd9, 32'h6000, 32'h5F0);
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
        n_checks++; if (fwd_stall !== 1'b1) begin n_fail++; $display("FAIL rstwait_stall: got %b expected 1", fwd_stall); end
        @(negedge clk);
        reset = 1'b1; flush = 1'b1; data_ok = 1'b1; es_to_ms_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0; flush = 1'b0; data_ok = 1'b0; es_to_ms_valid = 1'b0;
        #1;
        n_checks++; if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0 || fwd_valid !== 1'b0)
            begin n_fail++; $display("FAIL rstwait_state: got a%b v%b f%b expected 1 0 0", ms_allowin, ms_to_ws_valid, fwd_valid); end
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk32(1'b1, 3'b000, 1'b1, 1'b1, 5'd10, 32'h6000, 32'h600);
        exp_q.push_back({1'b1, 5'd10, 32'h1357_2468, 32'h600});
        @(negedge clk);
        es_to_ms_valid = 1'b0; data_ok = 1'b1; rdata = 32'h1357_2468;
        #1;
        exp_v = exp_q.pop_front();
        n_checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp_v)
            begin n_fail++; $display("FAIL rstwait_next: got v%b %h expected v1 %h", ms_to_ws_valid, ms_to_ws_bus, exp_v); end
        @(negedge clk);
        data_ok = 1'b0;
    endtask

    task automatic test_xlen64();
        @(negedge clk);
        es_valid64 = 1'b1; ws_allowin64 = 1'b1;
        es_bus64 = mk64(1'b1, 3'b000, 1'b1, 1'b1, 5'd11, 64'h1004, 32'h800);
        exp64_q.push_back({1'b1, 5'd11, 64'hFFFF_FFFF_8000_0000, 32'h800});
        @(negedge clk);
        es_bus64 = mk64(1'b1, 3'b110, 1'b1, 1'b1, 5'd12, 64'h1008, 32'h804);
        data_ok64 = 1'b1; rdata64 = 64'h8000_0000_0000_0000;
        #1;
        exp64_v = exp64_q.pop_front();
        n_checks++; if (ws_valid64 !== 1'b1 || ws_bus64 !== exp64_v)
            begin n_fail++; $display("FAIL x64_lw: got v%b %h expected v1 %h", ws_valid64, ws_bus64, exp64_v); end
        if (allowin64) exp64_q.push_back({1'b1, 5'd12, 64'h0123_4567_89AB_CDEF, 32'h804});
        @(negedge clk);
        es_valid64 = 1'b0; rdata64 = 64'h0123_4567_89AB_CDEF;
        #1;
        n_checks++; if (exp64_q.size() != 1) begin n_fail++; $display("FAIL x64_accept: got %0d queued expected 1", exp64_q.size()); end
        else begin
            exp64_v = exp64_q.pop_front();
            n_checks++; if (ws_valid64 !== 1'b1 || ws_bus64 !== exp64_v)
                begin n_fail++; $display("FAIL x64_ld: got v%b %h expected v1 %h", ws_valid64, ws_bus64, exp64_v); end
        end
        @(negedge clk);
        data_ok64 = 1'b0;
    endtask

    initial begin
        reset = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_allowin = 1'b1;
        data_ok = 1'b0; rdata = '0; flush = 1'b0;
        es_valid64 = 1'b0; es_bus64 = '0; ws_allowin64 = 1'b1;
        data_ok64 = 1'b0; rdata64 = '0; flush64 = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_alu();
        test_lb_stall();
        test_lhu_buffered();
        test_store();
        test_flush_cancel();
        test_back_to_back();
        test_reset_mid_wait();
        test_xlen64();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_load_stage.md
MEM_LOAD_STAGE -- requirements
Module: mem_load_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter REG_AW, default 5, register-index width.
REQ-003 SHALL have parameter PC_W, default 32, PC width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 es_to_ms_valid  input  1  EX stage offers an instruction.
REQ-007 ms_allowin  output  1  MEM accepts an instruction this cycle.
REQ-008 es_to_ms_bus  input  PC_W+XLEN+REG_AW+6  {mem_req, ld_op[2:0], res_from_mem, gr_we, dest, alu_result, pc}, MSB first.
REQ-009 ws_allowin  input  1  WB accepts this cycle.
REQ-010 ms_to_ws_valid  output  1  MEM offers an instruction to WB.
REQ-011 ms_to_ws_bus  output  1+REG_AW+XLEN+PC_W  {gr_we, dest, final_result, pc}.
REQ-012 data_sram_data_ok  input  1  read/write response, one per accepted request, in order.
REQ-013 data_sram_rdata  input  XLEN  read data, valid with data_ok.
REQ-014 flush  input  1  discard MEM instruction and any incoming EX instruction this cycle.
REQ-015 ms_fwd_valid / ms_fwd_dest / ms_fwd_data  output  1 / REG_AW / XLEN  bypass to ID.
REQ-016 ms_fwd_stall  output  1  bypass value not yet available.

Function
REQ-017 ms_allowin SHALL equal !ms_valid || (ms_ready_go && ws_allowin); ms_to_ws_valid = ms_valid && ms_ready_go && !flush.
REQ-018 On es_to_ms_valid && ms_allowin && !flush, the bus SHALL be registered and ms_valid set next cycle; else, if ms_allowin, ms_valid cleared.
REQ-019 mem_req=1 means EX had a request accepted; MEM SHALL wait for its data_ok; mem_req=0 means ms_ready_go=1 immediately.
REQ-020 ms_ready_go SHALL be 1 if !mem_req, or data_buf_valid, or (data_ok && cancel_cnt==0) in the current cycle.
REQ-021 A consumed data_ok arriving while ws_allowin=0 SHALL latch rdata into data_buf and set data_buf_valid; cleared when the instruction leaves MEM or is flushed.
REQ-022 2-bit cancel_cnt: on flush, SHALL increment by ([ms_valid && mem_req && no response yet] + [es_to_ms_valid && es mem_req]); each data_ok while cancel_cnt>0 SHALL decrement it and be ignored.
REQ-023 Simultaneous increment and decrement SHALL net; cancel_cnt never exceeds 2.
REQ-024 Load select: offset = alu_result[log2(XLEN/8)-1:0]; raw = rdata >> 8*offset.
REQ-025 ld_op: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LWU, 110 LD (XLEN=64 only); signed ops sign-extend, unsigned zero-extend to XLEN; LW at XLEN=32 passes 32 bits.
REQ-026 final_result SHALL be res_from_mem ? extended load : alu_result; data source is data_buf when data_buf_valid, else rdata.
REQ-027 ms_fwd_valid = ms_valid && gr_we && dest!=0; ms_fwd_data = final_result; ms_fwd_stall = ms_fwd_valid && res_from_mem && !ms_ready_go.
REQ-028 Stores (mem_req=1, res_from_mem=0) SHALL wait for data_ok, result = alu_result.

Reset
REQ-029 On reset: ms_valid=0, data_buf_valid=0, cancel_cnt=0; ms_to_ws_valid, ms_fwd_valid, ms_fwd_stall =0; ms_allowin=1 next cycle.
REQ-030 Reset SHALL override flush and data_ok; responses outstanding at reset are the memory side's responsibility.

Verification
REQ-031 ALU op (mem_req=0, alu_result=0x1234, dest=3, gr_we=1), ws_allowin=1 -> next cycle ms_to_ws_valid=1, final_result=0x1234, fwd_valid=1, fwd_stall=0.
REQ-032 LB, addr=...2, data_ok after 3 cycles with rdata=0x0080_0000 -> stall 3 cycles (fwd_stall=1), then final_result=0xFFFF_FF80.
REQ-033 LHU addr=...2, rdata=0x8001_0000 arrives while ws_allowin=0 -> buffered; ws_allowin=1 two cycles later -> final_result=0x0000_8001.
REQ-034 Flush with MEM load waiting and EX offering load -> cancel_cnt=2; next two data_oks ignored; third data_ok completes following load.
REQ-035 XLEN=64, LW addr=...4, rdata=0x8000_0000_0000_0000 -> final_result=0xFFFF_FFFF_8000_0000; LD passes full 64 bits.
REQ-036 Reset mid-wait with ms_valid=1 -> ms_valid=0, cancel_cnt=0, ms_allowin=1 next cycle.
